pe_frame_controller: RTL
========================

// Module: pe_frame_controller
// PURPOSE
//  Initiator for one background-removal pe. Latches a frame, starts the pe sum pass and
//  waits for its sum-done state. Forms the per-channel expected colour from the sums, then
//  starts the pe removal pass and captures the replaced pixels. Reports done to the host.
//  Sits between the host/frame buffer and the pe; replaces hand-sequencing of Start_Sum/Ack.
// PARAMETERS
//  NUM_PIXELS      4      pixels per frame; power of two, >=2
//  TIMEOUT_CYCLES  1024   max cycles waiting in either wait state before Error
//  CNT_W           16     width of Cycle_count
// PORTS
//  Clk            in   1             clock, all state on rising edge
//  Reset_n        in   1             asynchronous, active-low reset
//  Start          in   1             host: begin frame (sampled only in IDLE)
//  Host_ack       in   1             host: result consumed, release DONE
//  Threshold      in   8             colour distance threshold, latched on Start
//  Bg_r/Bg_g/Bg_b in   8 each        replacement background colour, latched on Start
//  Pix_r/g/b_in   in   8*NUM_PIXELS  frame pixels, pixel i at [8i+7:8i], latched on Start
//  Pix_r/g/b_out  out  8*NUM_PIXELS  captured result pixels
//  Frame_done     out  1             result valid; held until Host_ack
//  Busy           out  1             high in every state except IDLE and DONE
//  Error          out  1             timeout occurred; sticky until next accepted Start
//  Cycle_count    out  CNT_W         cycles from Start acceptance to DONE entry, saturating
//  Pe_start_sum   out  1             to pe Start_Sum
//  Pe_start_bg    out  1             to pe Start_BgRemoval
//  Pe_ack         out  1             to pe Ack
//  Pe_red/green/blue_in  out  8*NUM_PIXELS  latched frame, stable from Start to DONE
//  Pe_threshold, Pe_bg_r/g/b, Pe_red/green/blue_exp  out  8 each  pe operand inputs
//  Pe_qsd, Pe_qbgd       in   1             pe sum-done and bg-done state flags
//  Pe_red/green/blue_sum in   8*NUM_PIXELS  pe channel sums (unsigned)
//  Pe_red/green/blue_out in   8*NUM_PIXELS  pe replaced pixels
// BEHAVIOUR
//  Reset: state IDLE. Every output and register is 0, including Pix_*_out, exp, Cycle_count.
//  FSM: IDLE -> S_START -> S_WAIT -> S_EXP -> S_ACK -> B_START -> B_WAIT -> B_CAP -> B_ACK -> DONE.
//   IDLE: Start=1 -> latch frame/Threshold/Bg, clear Error and Cycle_count -> S_START.
//   S_START: Pe_start_sum=1 for exactly this cycle -> S_WAIT.
//   S_WAIT: Pe_qsd=1 -> S_EXP; timeout -> IDLE with Error=1, no Frame_done.
//   S_EXP: exp_c = Pe_c_sum >> log2(NUM_PIXELS), saturate to 8'hFF; register -> S_ACK.
//   S_ACK: Pe_ack=1 one cycle -> B_START.
//   B_START: Pe_start_bg=1 one cycle; exp regs already stable -> B_WAIT.
//   B_WAIT: Pe_qbgd=1 -> B_CAP; timeout as S_WAIT.
//   B_CAP: register Pe_*_out into Pix_*_out -> B_ACK.
//   B_ACK: Pe_ack=1 one cycle -> DONE.
//   DONE: Frame_done=1; Host_ack=1 -> IDLE. Start is ignored in this cycle.
//  Each Pe_* pulse is one cycle and registered. Pe_ack is never high with a Pe_start_* pulse.
//  Timeout counter resets on entry to each wait state and fires when count == TIMEOUT_CYCLES-1.
//  Pe_qsd/Pe_qbgd already high on entry to a wait state: advance next cycle.
//  Start outside IDLE is ignored; latched frame never changes mid-operation.
//  Pix_*_out hold the last good frame; they are not modified on timeout.
//  Latency with pe waits W1, W2 cycles: Start accept to Frame_done = 8 + W1 + W2 cycles.
//  Reset_n low mid-frame: immediate return to IDLE with all outputs 0; pe is reset separately.
// STRUCTURE
//  bgr_defines.vh (shared): state encodings, PIX_W=8, log2 helper function.
//  Sub-module pe_avg_div: sum >> shift with 8-bit saturation, one instance per channel.
//  One FSM always block, one timeout counter, one cycle counter, plus data registers.
// TESTING
//  Bench uses a behavioural pe model with configurable W1/W2 latency.
//  1 Frame R{61,61,61,204} G{133,133,133,0} B{198,198,198,0} -> exp R96 G99 B148; single pulses;
//    Frame_done only after B_ACK.
//  2 Model pe never raises Pe_qsd, TIMEOUT_CYCLES=16 -> Error=1, IDLE, Pe_start_bg never pulses.
//  3 Sum 0x500 with NUM_PIXELS=4 -> exp saturates to 8'hFF.
//  4 Start held high in DONE together with Host_ack -> IDLE, no new frame that cycle;
//    new frame starts next cycle.
//  5 Reset_n low in B_WAIT -> all outputs 0 asynchronously; next Start runs a full clean frame.
//  6 W1=3, W2=5 -> Cycle_count=16; input pixels changed mid-frame do not alter Pe_*_in.

Source files
------------

// File: rtl/pe_frame_controller_pkg.sv
// Shared types and helpers for the pe frame controller.
// State encoding, pixel width and a constant log2 helper.
package pe_frame_controller_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    S_START = 4'd1,
    S_WAIT  = 4'd2,
    S_EXP   = 4'd3,
    S_ACK   = 4'd4,
    B_START = 4'd5,
    B_WAIT  = 4'd6,
    B_CAP   = 4'd7,
    B_ACK   = 4'd8,
    DONE    = 4'd9
  } state_t;

  function automatic int log2_int(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_avg_div.sv
// Channel average: sum shifted down by log2(pixels).
// Anything that does not fit in a pixel clamps to full scale.
module pe_avg_div
  import pe_frame_controller_pkg::*;
#(
  parameter int SUM_W = 32,
  parameter int SHIFT = 2
) (
  input  logic [SUM_W-1:0] sum,
  output logic [PIX_W-1:0] avg
);

  logic [SUM_W-1:0] quot;

  assign quot = sum >> SHIFT;
  assign avg  = (|quot[SUM_W-1:PIX_W]) ? {PIX_W{1'b1}}
                                       : quot[PIX_W-1:0];

endmodule

// File: rtl/pe_frame_controller.sv
// Frame initiator for one background-removal pe.
// Sequences sum pass, expected colour, removal pass, capture.
module pe_frame_controller
  import pe_frame_controller_pkg::*;
#(
  parameter int NUM_PIXELS     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        Start,
  input  logic                        Host_ack,
  input  logic [PIX_W-1:0]            Threshold,
  input  logic [PIX_W-1:0]            Bg_r,
  input  logic [PIX_W-1:0]            Bg_g,
  input  logic [PIX_W-1:0]            Bg_b,
  input  logic [PIX_W*NUM_PIXELS-1:0] Pix_r_in,
  input  logic [PIX_W*NUM_PIXELS-1:0] Pix_g_in,
  input  logic [PIX_W*NUM_PIXELS-1:0] Pix_b_in,
  output logic [PIX_W*NUM_PIXELS-1:0] Pix_r_out,
  output logic [PIX_W*NUM_PIXELS-1:0] Pix_g_out,
  output logic [PIX_W*NUM_PIXELS-1:0] Pix_b_out,
  output logic                        Frame_done,
  output logic                        Busy,
  output logic                        Error,
  output logic [CNT_W-1:0]            Cycle_count,
  output logic                        Pe_start_sum,
  output logic                        Pe_start_bg,
  output logic                        Pe_ack,
  output logic [PIX_W*NUM_PIXELS-1:0] Pe_red_in,
  output logic [PIX_W*NUM_PIXELS-1:0] Pe_green_in,
  output logic [PIX_W*NUM_PIXELS-1:0] Pe_blue_in,
  output logic [PIX_W-1:0]            Pe_threshold,
  output logic [PIX_W-1:0]            Pe_bg_r,
  output logic [PIX_W-1:0]            Pe_bg_g,
  output logic [PIX_W-1:0]            Pe_bg_b,
  output logic [PIX_W-1:0]            Pe_red_exp,
  output logic [PIX_W-1:0]            Pe_green_exp,
  output logic [PIX_W-1:0]            Pe_blue_exp,
  input  logic                        Pe_qsd,
  input  logic                        Pe_qbgd,
  input  logic [PIX_W*NUM_PIXELS-1:0] Pe_red_sum,
  input  logic [PIX_W*NUM_PIXELS-1:0] Pe_green_sum,
  input  logic [PIX_W*NUM_PIXELS-1:0] Pe_blue_sum,
  input  logic [PIX_W*NUM_PIXELS-1:0] Pe_red_out,
  input  logic [PIX_W*NUM_PIXELS-1:0] Pe_green_out,
  input  logic [PIX_W*NUM_PIXELS-1:0] Pe_blue_out
);

  localparam int BUS_W = PIX_W * NUM_PIXELS;
  localparam int SHIFT = log2_int(NUM_PIXELS);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [TO_W-1:0]   to_cnt;
  logic              to_hit;
  logic              accept;
  logic              in_wait;
  logic              in_busy;
  logic [PIX_W-1:0]  avg_r;
  logic [PIX_W-1:0]  avg_g;
  logic [PIX_W-1:0]  avg_b;

  assign accept  = (state == IDLE) && Start;
  assign in_wait = (state == S_WAIT) || (state == B_WAIT);
  assign in_busy = (state != IDLE) && (state != DONE);
  assign to_hit  = (to_cnt == TO_LAST);

  pe_avg_div #(.SUM_W(BUS_W), .SHIFT(SHIFT)) u_div_r (
    .sum (Pe_red_sum),
    .avg (avg_r)
  );

  pe_avg_div #(.SUM_W(BUS_W), .SHIFT(SHIFT)) u_div_g (
    .sum (Pe_green_sum),
    .avg (avg_g)
  );

  pe_avg_div #(.SUM_W(BUS_W), .SHIFT(SHIFT)) u_div_b (
    .sum (Pe_blue_sum),
    .avg (avg_b)
  );

  // Frame sequencer with registered pe pulses and host flags.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      Pe_start_sum <= 1'b0;
      Pe_start_bg  <= 1'b0;
      Pe_ack       <= 1'b0;
      Busy         <= 1'b0;
      Frame_done   <= 1'b0;
      Error        <= 1'b0;
    end else begin
      Pe_start_sum <= 1'b0;
      Pe_start_bg  <= 1'b0;
      Pe_ack       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            state        <= S_START;
            Pe_start_sum <= 1'b1;
            Busy         <= 1'b1;
            Error        <= 1'b0;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (Pe_qsd) begin
            state <= S_EXP;
          end else if (to_hit) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Error <= 1'b1;
          end
        end
        S_EXP: begin
          state  <= S_ACK;
          Pe_ack <= 1'b1;
        end
        S_ACK: begin
          state       <= B_START;
          Pe_start_bg <= 1'b1;
        end
        B_START: state <= B_WAIT;
        B_WAIT: begin
          if (Pe_qbgd) begin
            state <= B_CAP;
          end else if (to_hit) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Error <= 1'b1;
          end
        end
        B_CAP: begin
          state  <= B_ACK;
          Pe_ack <= 1'b1;
        end
        B_ACK: begin
          state      <= DONE;
          Busy       <= 1'b0;
          Frame_done <= 1'b1;
        end
        DONE: begin
          if (Host_ack) begin
            state      <= IDLE;
            Frame_done <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          Busy       <= 1'b0;
          Frame_done <= 1'b0;
        end
      endcase
    end
  end

  // Wait-state timeout: zero outside waits, so each entry starts at 0.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      to_cnt <= '0;
    end else if (in_wait) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  // Saturating count of busy cycles since the frame was accepted.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Cycle_count <= '0;
    end else if (accept) begin
      Cycle_count <= '0;
    end else if (in_busy && (Cycle_count != {CNT_W{1'b1}})) begin
      Cycle_count <= Cycle_count + CNT_W'(1);
    end
  end

  // Frame latch, expected colour and captured result pixels.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Pe_red_in    <= '0;
      Pe_green_in  <= '0;
      Pe_blue_in   <= '0;
      Pe_threshold <= '0;
      Pe_bg_r      <= '0;
      Pe_bg_g      <= '0;
      Pe_bg_b      <= '0;
      Pe_red_exp   <= '0;
      Pe_green_exp <= '0;
      Pe_blue_exp  <= '0;
      Pix_r_out    <= '0;
      Pix_g_out    <= '0;
      Pix_b_out    <= '0;
    end else begin
      if (accept) begin
        Pe_red_in    <= Pix_r_in;
        Pe_green_in  <= Pix_g_in;
        Pe_blue_in   <= Pix_b_in;
        Pe_threshold <= Threshold;
        Pe_bg_r      <= Bg_r;
        Pe_bg_g      <= Bg_g;
        Pe_bg_b      <= Bg_b;
      end
      if (state == S_EXP) begin
        Pe_red_exp   <= avg_r;
        Pe_green_exp <= avg_g;
        Pe_blue_exp  <= avg_b;
      end
      if (state == B_CAP) begin
        Pix_r_out <= Pe_red_out;
        Pix_g_out <= Pe_green_out;
        Pix_b_out <= Pe_blue_out;
      end
    end
  end

endmodule
